nn_frame_loader: RTL and testbench
==================================

Name: nn_frame_loader

Overview:
Upstream feeder for the combinational neural_net core. It accepts a serial 8-bit pixel stream over a valid/ready handshake and converts each pixel to the 32-bit Q16.16 word format used by the network. It assembles a full input vector and holds that vector stable while the combinational layers settle. It then flags the frame as valid until the consumer acknowledges it.

Parameters:
N_INPUTS, 784, number of pixels per frame; must equal LAYER_WIDTHS[0] of the network
SETTLE_CYCLES, 16, cycles the vector is held stable before frame_valid; 0 is legal
PIX_SHIFT, 8, left shift applied to the 8-bit pixel to form the Q16.16 word (8 gives p/256)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
pix_data  in  8  unsigned pixel value
pix_valid  in  1  pix_data is valid this cycle
pix_sof  in  1  qualifies pix_valid; this pixel is index 0 of a new frame
pix_ready  out  1  loader can accept a pixel this cycle
abort  in  1  discard the current frame or hold state and return to LOAD
frame_ack  in  1  consumer has captured the outputs; release the frame
inputs  out  32 x N_INPUTS  unpacked array driving neural_net.inputs
settling  out  1  high during SETTLE
frame_valid  out  1  network outputs correspond to inputs and are settled
pix_count  out  $clog2(N_INPUTS+1)  pixels accepted in the current frame

Behaviour:
Clock and reset:
- One clock, clk. Reset is synchronous and active-low on rst_n. All state updates on posedge clk.
- Reset values: inputs all 0, pix_count 0, settling 0, frame_valid 0, state LOAD, settle counter 0.
- pix_ready is forced to 0 while rst_n is low.

States: LOAD, SETTLE, HOLD.
- pix_ready = (state == LOAD) && rst_n.
- settling = (state == SETTLE).
- frame_valid = (state == HOLD).

Handshake:
- A pixel is accepted when pix_valid && pix_ready.
- Conversion: word = zero-extended pix_data << PIX_SHIFT, 32 bits wide. No rounding or sign; truncate above bit 31.

LOAD:
- An accepted pixel with pix_sof=0 writes to inputs[pix_count]; pix_count increments.
- An accepted pixel with pix_sof=1 writes to inputs[0]; pix_count becomes 1. This is a resync: prior partial data is not cleared.
- When the accepted pixel is index N_INPUTS-1: next state SETTLE, settle counter loads SETTLE_CYCLES, pix_count becomes N_INPUTS.
- If SETTLE_CYCLES == 0, go straight to HOLD instead.

SETTLE:
- The counter decrements each cycle. At 1 the next state is HOLD.
- Latency: last pixel accepted at cycle t gives frame_valid=1 from cycle t+1+SETTLE_CYCLES.

HOLD:
- inputs stay stable.
- frame_ack=1 gives next state LOAD with pix_count 0; frame_valid drops the next cycle.
- frame_ack is ignored in LOAD and SETTLE.

abort:
- abort=1 in any state gives next state LOAD with pix_count 0.
- abort has priority over a same-cycle accepted pixel (that pixel is dropped) and over frame_ack.
- inputs are not cleared (stale data is allowed).

Stability invariant:
- inputs change only on an accepted pixel in LOAD.
- They never change in SETTLE or HOLD.

Reset mid-operation:
- Synchronous return to reset values on the next edge, regardless of state.

Decomposition:
- nn_pkg holds: WORD_W=32, FRAC_W=16, state enum (LOAD, SETTLE, HOLD), and function pix_to_word(pix, shift).
- nn_pkg is shared with the downstream argmax/readout block.
- No sub-module is needed. The settle counter is inline, a single always_ff plus next-state logic.

Test Plan:
1. Reset, then 4 pixels 0x10,0x20,0x30,0xFF (N_INPUTS=4, SETTLE_CYCLES=3). Required: inputs = 0x1000,0x2000,0x3000,0xFF00; pix_ready low from the cycle after the last accept; frame_valid high exactly 4 cycles after the last accept.
2. In HOLD, drive pix_valid with new data for 10 cycles. Required: pix_ready=0 and inputs unchanged. Then pulse frame_ack; required: frame_valid=0 and pix_ready=1 the next cycle, pix_count=0.
3. Send 2 pixels, then a pixel 0x55 with pix_sof=1. Required: inputs[0]=0x5500, pix_count=1; frame completes after 3 more pixels.
4. Send abort with pix_valid in LOAD at pix_count=2. Required: pixel dropped, pix_count=0. Repeat abort in SETTLE; required: settling drops next cycle, frame_valid never asserts.
5. With SETTLE_CYCLES=0: required: frame_valid the cycle after the last accept. Assert frame_ack in SETTLE (SETTLE_CYCLES=3); required: ignored.
6. Drive rst_n=0 for one cycle while in HOLD. Required: frame_valid=0, inputs all 0, pix_ready=0 during reset and 1 after release.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: definitions shared by the frame loader and the downstream
// argmax/readout block.
//   WORD_W      - width of one network word (Q16.16)
//   FRAC_W      - fractional bits of the network word
//   nn_state_t  - loader state encoding (LOAD, SETTLE, HOLD)
//   pix_to_word - converts an unsigned 8-bit pixel to a network word
package nn_pkg;

  localparam int WORD_W = 32;
  localparam int FRAC_W = 16;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } nn_state_t;

  // The pixel is zero-extended before the shift, so the result is never
  // negative. Bits shifted past bit 31 are truncated, with no rounding.
  function automatic logic [WORD_W-1:0] pix_to_word(input logic [7:0] pix,
                                                    input int unsigned shift);
    logic [WORD_W-1:0] wide;
    wide = {{(WORD_W-8){1'b0}}, pix};
    return wide << shift;
  endfunction

endpackage

// File: rtl/nn_frame_loader.sv
// nn_frame_loader: serial pixel front end for the combinational neural_net.
// It collects N_INPUTS pixels into a Q16.16 input vector. It then holds that
// vector stable for SETTLE_CYCLES cycles while the layers settle. After that
// it presents the frame as valid until the consumer acknowledges it.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   pix_data     unsigned 8-bit pixel
//   pix_valid    pix_data valid this cycle
//   pix_sof      with pix_valid: this pixel is index 0 of a new frame
//   pix_ready    loader accepts a pixel this cycle (LOAD and out of reset)
//   abort        drop the current frame or hold state and return to LOAD
//   frame_ack    consumer has captured the network outputs
//   inputs       input vector driving neural_net.inputs
//   settling     high while the vector settles through the network
//   frame_valid  network outputs are settled and match inputs
//   pix_count    pixels accepted in the current frame
module nn_frame_loader
  import nn_pkg::*;
#(
  parameter int N_INPUTS      = 784,
  parameter int SETTLE_CYCLES = 16,
  parameter int PIX_SHIFT     = FRAC_W - 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  pix_data,
  input  logic                        pix_valid,
  input  logic                        pix_sof,
  output logic                        pix_ready,
  input  logic                        abort,
  input  logic                        frame_ack,
  output logic [WORD_W-1:0]           inputs [N_INPUTS],
  output logic                        settling,
  output logic                        frame_valid,
  output logic [$clog2(N_INPUTS+1)-1:0] pix_count
);

  localparam int CNT_W  = $clog2(N_INPUTS + 1);
  // Keep the counter at least 1 bit wide so SETTLE_CYCLES = 0 still builds.
  localparam int SCNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(N_INPUTS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(N_INPUTS);
  localparam logic [SCNT_W-1:0] SETTLE_LD  = SCNT_W'(SETTLE_CYCLES);

  nn_state_t         state;
  logic [SCNT_W-1:0] settle_cnt;

  logic              accept;
  logic [CNT_W-1:0]  wr_idx;
  logic              last_pix;
  logic [WORD_W-1:0] pix_word;

  assign pix_ready   = (state == LOAD) && rst_n;
  assign settling    = (state == SETTLE);
  assign frame_valid = (state == HOLD);

  // A start-of-frame pixel always lands in slot 0. Earlier partial data
  // is left in place, because the frame overwrites it anyway.
  always_comb begin
    accept   = pix_valid && pix_ready;
    wr_idx   = pix_sof ? '0 : pix_count;
    last_pix = (wr_idx == LAST_IDX);
    pix_word = pix_to_word(pix_data, PIX_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LOAD;
      pix_count  <= '0;
      settle_cnt <= '0;
      for (int i = 0; i < N_INPUTS; i++) begin
        inputs[i] <= '0;
      end
    end else if (abort) begin
      // abort takes priority over a same-cycle pixel and over frame_ack.
      // The vector is left stale.
      state     <= LOAD;
      pix_count <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept && (wr_idx <= LAST_IDX)) begin
            inputs[wr_idx] <= pix_word;
            if (last_pix) begin
              pix_count  <= FULL_CNT;
              settle_cnt <= SETTLE_LD;
              state      <= (SETTLE_CYCLES == 0) ? HOLD : SETTLE;
            end else begin
              pix_count <= wr_idx + CNT_W'(1);
            end
          end
        end
        SETTLE: begin
          // Leave SETTLE after SETTLE_CYCLES cycles, so the frame shows
          // as valid SETTLE_CYCLES+1 cycles after the last pixel.
          settle_cnt <= settle_cnt - SCNT_W'(1);
          if (settle_cnt <= SCNT_W'(1)) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (frame_ack) begin
            state     <= LOAD;
            pix_count <= '0;
          end
        end
        default: begin
          state     <= LOAD;
          pix_count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_frame_loader.sv
// Directed bench for nn_frame_loader with N_INPUTS=4. The main instance has
// SETTLE_CYCLES=3. A second instance has SETTLE_CYCLES=0 and covers the
// zero-settle path.
module tb_nn_frame_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pix_data;
  logic        pix_valid, pix_sof, abort, frame_ack;
  logic        pix_ready, settling, frame_valid;
  logic [31:0] ins [4];
  logic [2:0]  pix_count;

  logic [7:0]  z_data;
  logic        z_valid, z_sof, z_abort, z_ack;
  logic        z_ready, z_settling, z_fv;
  logic [31:0] z_ins [4];
  logic [2:0]  z_count;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  nn_frame_loader #(.N_INPUTS(4), .SETTLE_CYCLES(3), .PIX_SHIFT(8)) dut (
    .clk(clk), .rst_n(rst_n), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_ready(pix_ready), .abort(abort),
    .frame_ack(frame_ack), .inputs(ins), .settling(settling),
    .frame_valid(frame_valid), .pix_count(pix_count)
  );

  nn_frame_loader #(.N_INPUTS(4), .SETTLE_CYCLES(0), .PIX_SHIFT(8)) dut_z (
    .clk(clk), .rst_n(rst_n), .pix_data(z_data), .pix_valid(z_valid),
    .pix_sof(z_sof), .pix_ready(z_ready), .abort(z_abort),
    .frame_ack(z_ack), .inputs(z_ins), .settling(z_settling),
    .frame_valid(z_fv), .pix_count(z_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic sof);
    pix_data  = d;
    pix_sof   = sof;
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_z(input logic [7:0] d, input logic sof);
    z_data  = d;
    z_sof   = sof;
    z_valid = 1'b1;
    tick();
    z_valid = 1'b0;
    z_sof   = 1'b0;
  endtask

  // Returns the number of ticks until frame_valid rises (bounded).
  task automatic wait_fv(output int n);
    n = 0;
    while (!frame_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    logic seen;
    rst_n = 1'b0; pix_data = '0; pix_valid = 0; pix_sof = 0; abort = 0; frame_ack = 0;
    z_data = '0; z_valid = 0; z_sof = 0; z_abort = 0; z_ack = 0;
    tick(); tick();
    chk("rst_ready",  pix_ready, 0);
    chk("rst_fv",     frame_valid, 0);
    chk("rst_count",  pix_count, 0);
    chk("rst_settle", settling, 0);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", pix_ready, 1);

    // 1: basic frame and settle latency
    send(8'h10, 1'b1);
    send(8'h20, 1'b0);
    send(8'h30, 1'b0);
    chk("t1_count3", pix_count, 3);
    send(8'hFF, 1'b0);
    chk("t1_ready_lo", pix_ready, 0);
    chk("t1_settling", settling, 1);
    chk("t1_count4", pix_count, 4);
    chk("t1_in0", ins[0], 32'h1000);
    chk("t1_in1", ins[1], 32'h2000);
    chk("t1_in2", ins[2], 32'h3000);
    chk("t1_in3", ins[3], 32'hFF00);
    wait_fv(n);
    chk("t1_latency", n, 3);   // accept at t -> valid at t+4
    chk("t1_settle_lo", settling, 0);

    // 2: pixels ignored in HOLD, then ack
    pix_data = 8'hAA; pix_valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    pix_valid = 1'b0;
    chk("t2_ready_lo", pix_ready, 0);
    chk("t2_fv", frame_valid, 1);
    chk("t2_in0", ins[0], 32'h1000);
    chk("t2_in3", ins[3], 32'hFF00);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    chk("t2_fv_lo", frame_valid, 0);
    chk("t2_ready", pix_ready, 1);
    chk("t2_count", pix_count, 0);

    // 3: sof resync
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    send(8'h55, 1'b1);
    chk("t3_in0", ins[0], 32'h5500);
    chk("t3_count", pix_count, 1);
    chk("t3_in1_kept", ins[1], 32'h0200);
    send(8'h66, 1'b0);
    send(8'h77, 1'b0);
    chk("t3_not_done", settling, 0);
    send(8'h88, 1'b0);
    chk("t3_settling", settling, 1);
    chk("t3_in3", ins[3], 32'h8800);
    wait_fv(n);
    chk("t3_latency", n, 3);
    frame_ack = 1'b1; tick(); frame_ack = 1'b0;

    // 4: abort in LOAD drops the pixel; abort in SETTLE
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    chk("t4_count2", pix_count, 2);
    pix_data = 8'h99; pix_valid = 1'b1; abort = 1'b1;
    tick();
    pix_valid = 1'b0; abort = 1'b0;
    chk("t4_count0", pix_count, 0);
    chk("t4_dropped", ins[2], 32'h7700);
    send(8'h01, 1'b1); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    chk("t4_in_settle", settling, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_settle_lo", settling, 0);
    chk("t4_ready", pix_ready, 1);
    chk("t4_count_ab", pix_count, 0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | frame_valid;
    end
    chk("t4_no_fv", seen, 0);

    // 5a: SETTLE_CYCLES=0 -> valid the cycle after the last accept
    send_z(8'h01, 1'b1); send_z(8'h02, 1'b0); send_z(8'h03, 1'b0);
    chk("t5_z_fv_lo", z_fv, 0);
    send_z(8'h04, 1'b0);
    chk("t5_z_fv", z_fv, 1);
    chk("t5_z_settling", z_settling, 0);
    chk("t5_z_in3", z_ins[3], 32'h0400);

    // 5b: frame_ack ignored in SETTLE
    send(8'hA1, 1'b1); send(8'hA2, 1'b0); send(8'hA3, 1'b0); send(8'hA4, 1'b0);
    frame_ack = 1'b1;
    tick(); tick();
    frame_ack = 1'b0;
    chk("t5_ack_ign", settling, 1);
    tick();
    chk("t5_fv", frame_valid, 1);
    chk("t5_in0", ins[0], 32'hA100);

    // 6: reset while in HOLD
    rst_n = 1'b0;
    #1;
    chk("t6_ready_in_rst", pix_ready, 0);
    tick();
    chk("t6_fv", frame_valid, 0);
    chk("t6_ready_rst", pix_ready, 0);
    for (int i = 0; i < 4; i++) chk("t6_in_zero", ins[i], 0);
    chk("t6_z_fv", z_fv, 0);
    rst_n = 1'b1;
    #1;
    chk("t6_ready_rel", pix_ready, 1);
    tick();
    chk("t6_ready_after", pix_ready, 1);
    chk("t6_count", pix_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
